latch_serial_driver: RTL and testbench

Serializes a parallel word onto the single-bit `d` input of a downstream level-triggered D latch. It generates the latch's level enable so that the enable is never high while data changes. The block sits directly upstream of the latch. It accepts a word via a valid/ready handshake, presents one bit per bit period MSB-first, opens the latch only in the middle of each period, and pulses `done` when the word has been delivered.

---
 rtl/latch_drv_pkg.sv | 15 +
 rtl/latch_serial_driver_timer.sv | 54 +++++
 rtl/latch_serial_driver.sv | 111 +++++++++++
 tb/tb_latch_serial_driver.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/latch_drv_pkg.sv
// Shared types and default sizing for the latch serial driver.
package latch_drv_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_BIT_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_OPEN  = 3'd2,
        ST_CLOSE = 3'd3,
        ST_DONE  = 3'd4
    } drv_state_e;

endpackage

// File: rtl/latch_serial_driver_timer.sv
// Cycle counter for one bit period. The phase outputs describe the cycle that
// follows the coming clock edge, so the driver can register its outputs from them.
module bit_period_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic phase_setup,
    output logic phase_open,
    output logic phase_close,
    output logic period_end
);

    localparam int            CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;

    // Last cycle of the current period; a start here chains straight into the next one.
    assign period_end = active_q && (cnt_q == LAST);

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (period_end) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (active_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        phase_setup = active_d && (cnt_d == '0);
        phase_close = active_d && (cnt_d == LAST);
        phase_open  = active_d && !phase_setup && !phase_close;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/latch_serial_driver.sv
// Serializes a word MSB-first onto a level-triggered latch, opening the latch
// only mid-period so d_out never moves while the enable is high.
module latch_serial_driver
    import latch_drv_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             d_out,
    output logic             latch_en,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 2 || BIT_CYCLES < 3) begin : g_bad_param
        $error("latch_serial_driver: need WIDTH >= 2 and BIT_CYCLES >= 3");
    end

    localparam int            BW       = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    drv_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             d_out_q, d_out_d;
    logic             latch_en_q, busy_q, done_q;

    logic accept, last_bit, tmr_start;
    logic ph_setup, ph_open, ph_close, period_end;

    assign din_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = din_valid && din_ready;
    assign last_bit  = (bit_q == LAST_BIT);
    // Restart the period timer on accept and on every CLOSE that is not the last bit.
    assign tmr_start = accept || (period_end && !last_bit);

    bit_period_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .start       (tmr_start),
        .phase_setup (ph_setup),
        .phase_open  (ph_open),
        .phase_close (ph_close),
        .period_end  (period_end)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        d_out_d = d_out_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = din;
                    d_out_d = din[WIDTH-1];
                    bit_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP, ST_OPEN: begin
                if (ph_open)       state_d = ST_OPEN;
                else if (ph_close) state_d = ST_CLOSE;
            end
            ST_CLOSE: begin
                // The timer only re-enters setup when another bit remains.
                if (ph_setup) begin
                    shift_d = shift_q << 1;
                    d_out_d = shift_q[WIDTH-2];
                    bit_d   = bit_q + 1'b1;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            d_out_q    <= 1'b0;
            latch_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            d_out_q    <= d_out_d;
            latch_en_q <= (state_d == ST_OPEN);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign d_out    = d_out_q;
    assign latch_en = latch_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_latch_serial_driver.sv
// Directed checks of the latch serial driver in an 8x4 and a 5x3 configuration.
module tb_latch_serial_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] a_din = '0;
    logic       a_valid = 1'b0;
    logic       a_rdy, a_d, a_le, a_busy, a_done;
    logic [4:0] b_din = '0;
    logic       b_valid = 1'b0;
    logic       b_rdy, b_d, b_le, b_busy, b_done;

    logic a_q = 1'b0;
    logic b_q = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    latch_serial_driver #(.WIDTH(8), .BIT_CYCLES(4)) u_a (
        .clk(clk), .rst(rst), .din(a_din), .din_valid(a_valid), .din_ready(a_rdy),
        .d_out(a_d), .latch_en(a_le), .busy(a_busy), .done(a_done)
    );

    latch_serial_driver #(.WIDTH(5), .BIT_CYCLES(3)) u_b (
        .clk(clk), .rst(rst), .din(b_din), .din_valid(b_valid), .din_ready(b_rdy),
        .d_out(b_d), .latch_en(b_le), .busy(b_busy), .done(b_done)
    );

    // Downstream level-triggered latches
    always @* if (a_le) a_q = a_d;
    always @* if (b_le) b_q = b_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // d_out may only move while latch_en is low both before and after the edge
    logic pa_d = 1'b0, pa_le = 1'b0, pb_d = 1'b0, pb_le = 1'b0;
    logic rst_edge = 1'b1;
    always @(posedge clk) rst_edge <= rst;
    always @(negedge clk) begin
        if (!rst_edge && (a_d !== pa_d)) chk("inv_a", {31'd0, a_le | pa_le}, 32'd0);
        if (!rst_edge && (b_d !== pb_d)) chk("inv_b", {31'd0, b_le | pb_le}, 32'd0);
        pa_d  <= a_d;
        pa_le <= a_le;
        pb_d  <= b_d;
        pb_le <= b_le;
    end

    // Caller has already presented the word; the next posedge is the accept edge T.
    task automatic run_word(input bit sel, input logic [7:0] word, input int w, input int bc,
                            input logic nv, input logic [7:0] nd);
        int total, k, ph;
        logic [4:0] obs, exp;
        logic e_d, e_le, q;
        total = w * bc;
        for (int n = 1; n <= total + 2; n++) begin
            @(negedge clk);
            if (n == 1) begin
                if (sel) begin b_valid = nv; b_din = nd[4:0]; end
                else     begin a_valid = nv; a_din = nd;      end
            end
            obs = sel ? {b_d, b_le, b_busy, b_done, b_rdy} : {a_d, a_le, a_busy, a_done, a_rdy};
            q   = sel ? b_q : a_q;
            k = 0; ph = 0;
            if (n <= total) begin
                k    = (n - 1) / bc;
                ph   = (n - 1) % bc;
                e_d  = word[w-1-k];
                e_le = (ph >= 1) && (ph <= bc - 2);
                exp  = {e_d, e_le, 1'b1, 1'b0, 1'b0};
            end else if (n == total + 1) begin
                exp = {word[0], 1'b0, 1'b1, 1'b1, 1'b0};
            end else begin
                exp = {word[0], 1'b0, 1'b0, 1'b0, 1'b1};
            end
            chk($sformatf("w%0h n%0d {d,le,busy,done,rdy}", word, n), {27'd0, obs}, {27'd0, exp});
            if (n <= total && ph == bc - 1)
                chk($sformatf("w%0h latch_q bit%0d", word, k), {31'd0, q}, {31'd0, word[w-1-k]});
        end
        chk($sformatf("w%0h latch_q final", word), {31'd0, sel ? b_q : a_q}, {31'd0, word[0]});
    endtask

    initial begin
        logic seen_done;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst outs", {27'd0, a_d, a_le, a_busy, a_done, a_rdy}, 32'd0);
        chk("rst b outs", {27'd0, b_d, b_le, b_busy, b_done, b_rdy}, 32'd0);
        rst = 1'b0;
        #1 chk("rdy after rst", {30'd0, a_rdy, b_rdy}, 32'd3);

        // Single word
        @(negedge clk);
        a_din = 8'hA5; a_valid = 1'b1;
        run_word(1'b0, 8'hA5, 8, 4, 1'b0, 8'h00);

        // Back-to-back with valid held; FF shown during the first word must not be taken
        @(negedge clk);
        a_din = 8'h3C; a_valid = 1'b1;
        run_word(1'b0, 8'h3C, 8, 4, 1'b1, 8'hFF);
        run_word(1'b0, 8'hFF, 8, 4, 1'b0, 8'h00);

        // Reset in the middle of a word
        @(negedge clk);
        a_din = 8'hA5; a_valid = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) a_valid = 1'b0;
        end
        chk("mid le before rst", {31'd0, a_le}, 32'd1);
        rst = 1'b1;
        #1 chk("rdy in rst", {31'd0, a_rdy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post rst {d,le,busy,done,rdy}", {27'd0, a_d, a_le, a_busy, a_done, a_rdy}, 32'd1);
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen_done = seen_done | a_done | a_busy;
        end
        chk("no done/busy after abort", {31'd0, seen_done}, 32'd0);
        a_din = 8'h81; a_valid = 1'b1;
        run_word(1'b0, 8'h81, 8, 4, 1'b0, 8'h00);

        // Minimum bit period, odd width
        @(negedge clk);
        b_din = 5'b10110; b_valid = 1'b1;
        run_word(1'b1, 8'b0001_0110, 5, 3, 1'b0, 8'h00);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
